store_commit_port: RTL
======================

# store_commit_port

Memory-side responder for the ROB's commit-time memory requests: committed stores (`if_out_mem`) and IO-mapped loads (`if_out_mem_io`). It sits between the ROB and the 8-bit RAM/IO bus. It serialises each request into byte accesses under a bus request/grant handshake with the memory arbiter. It then answers with the one-cycle `if_stored` / `if_get_mem` pulses the ROB waits on.

## Interface
- `IO_ADDR`, 32'h30000, base of the IO region; IO loads read this address; addresses ≥ `IO_ADDR` are IO.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global enable; when low, all state is frozen and `mem_wr` is forced 0.
- `clear`  in  1  pipeline flush from ROB.
- `if_out_mem`  in  1  one-cycle store-commit request.
- `out_mem_size`  in  6  byte count: 1 or 2 selects that count; any other value selects 4.
- `out_mem_addr`  in  32  store byte address.
- `out_mem_data`  in  32  store data, little-endian.
- `if_stored`  out  1  one-cycle pulse: store finished.
- `if_out_mem_io`  in  1  one-cycle IO-load request.
- `if_get_mem`  out  1  one-cycle pulse: `data_mem` is valid.
- `data_mem`  out  32  IO byte, zero-extended; held until the next IO load.
- `bus_req`  out  1  request ownership of the RAM bus.
- `bus_gnt`  in  1  arbiter grant; sampled each edge.
- `mem_a`  out  32  bus address.
- `mem_dout`  out  8  write byte.
- `mem_wr`  out  1  1 = write, 0 = read.
- `mem_din`  in  8  read byte; valid the cycle after its address.
- `io_buffer_full`  in  1  IO sink cannot accept a byte.

## Operation
- Reset value of every output is 0: `if_stored`, `if_get_mem`, `data_mem`, `bus_req`, `mem_a`, `mem_dout`, `mem_wr`. FSM resets to IDLE and pending flags clear.
- Request latching:
  - `if_out_mem` and `if_out_mem_io` are latched into one pending flag each, together with the store addr/data/size, in any state.
  - A second request of the same kind while its flag is set is ignored.
  - Stores have priority over IO loads.
- FSM states:
  - IDLE: if any flag is set, go to REQ.
  - REQ: `bus_req`=1. On an edge with `bus_gnt`=1, go to WR (store) or RD (IO load).
  - WR: drives `mem_a`=addr+i (32-bit wrap), `mem_dout`=data[8i+7:8i], `mem_wr`=1, with i = 0..N-1 and one byte per cycle. After byte N-1, go to DONE_S.
  - RD: drives `mem_a`=`IO_ADDR`, `mem_wr`=0 for one cycle, then goes to CAP.
  - CAP: captures `data_mem`={24'b0,`mem_din`}, then goes to DONE_L.
  - DONE_S: pulses `if_stored`, clears the store flag, `bus_req`=0, returns to IDLE.
  - DONE_L: pulses `if_get_mem`, clears the IO flag, `bus_req`=0, returns to IDLE.
- `bus_req` stays 1 from REQ through the last bus cycle. Dropping `bus_gnt` mid-transfer is an arbiter protocol violation and is not handled.
- `clear`:
  - Discards a pending or in-flight IO load; no `if_get_mem` is produced and the FSM returns to IDLE next cycle.
  - A committed store that is latched or in flight still completes all its bytes, because it is architecturally committed. Its `if_stored` pulse is suppressed if `clear` was seen since it was accepted.
- Reset asserted mid-operation aborts immediately and returns all outputs to their reset values.

## Timing
- Request seen at edge k → REQ during cycle k+1.
- With `bus_gnt` high, the first WR cycle is k+2. `if_stored` is high in cycle k+2+N, so SW gives cycle k+6.
- IO load with immediate grant: RD in cycle k+2, CAP in k+3, `if_get_mem` high in k+4.
- Back-to-back requests: at least one IDLE cycle separates transactions.

## Configuration
- `STORE_COMMIT_IOFULL_EN` defined: a WR byte whose address is ≥ `IO_ADDR` stalls while `io_buffer_full`=1. During the stall `mem_wr`=0, i is held and `mem_a`/`mem_dout` are held.
- Not defined: `io_buffer_full` is ignored and WR never stalls.

## Structure
- The shared defines header holds `addrWidth`, `dataWidth`, `IO_ADDR`, the size encodings (1/2/4) and the FSM state encodings.
- One natural sub-module, `byte_lane_sel`, is combinational: it takes data, i and N and produces the byte and last-byte flag.

## Test plan
- SW: addr 0x100, data 0xDEADBEEF, `bus_gnt`=1 → writes 0xEF@0x100, 0xBE@0x101, 0xAD@0x102, 0xDE@0x103 in cycles k+2..k+5, then `if_stored` in k+6.
- SB: addr 0x7, data 0x12345678, `bus_gnt` delayed 3 cycles → `bus_req` held high, a single write of 0x78@0x7, then one `if_stored` pulse.
- IO load: `mem_din`=0x41 → `mem_a`=0x30000 with `mem_wr`=0 in k+2; `if_get_mem` in k+4 with `data_mem`=0x00000041.
- `clear` one cycle after an IO request → no `if_get_mem`, FSM back in IDLE, `bus_req`=0.
- `if_out_mem` and `if_out_mem_io` in the same cycle → store completes first, then the IO load; each pulse occurs exactly once.
- With `STORE_COMMIT_IOFULL_EN`: SW to 0x30004 with `io_buffer_full` high for 2 cycles at byte 1 → `mem_wr`=0 for 2 cycles, all 4 bytes written, and `if_stored` is 2 cycles later than the no-stall case. Also toggle `rdy` low mid-WR → FSM frozen, no byte lost.

Source files
------------

// File: rtl/store_commit_port_pkg.sv
// Shared definitions for store_commit_port: bus widths, IO base address,
// access-size encodings, FSM state encoding and the size decode helper.
package store_commit_port_pkg;

  localparam int addrWidth = 32;
  localparam int dataWidth = 32;

  localparam logic [31:0] IO_ADDR = 32'h0003_0000;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WR     = 3'd2,
    RD     = 3'd3,
    CAP    = 3'd4,
    DONE_S = 3'd5,
    DONE_L = 3'd6
  } state_t;

  // Byte count of a committed store: only 1 and 2 are honoured, all else is a word.
  function automatic logic [2:0] size_bytes(input logic [5:0] sz);
    case (sz)
      6'd1:    return SIZE_B;
      6'd2:    return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/store_commit_port_lane.sv
// byte_lane_sel: picks byte idx of a little-endian word and flags whether
// idx is the final byte of an nbytes-long access.
module byte_lane_sel
  import store_commit_port_pkg::*;
(
  input  logic [dataWidth-1:0] data_i,
  input  logic [1:0]           idx_i,
  input  logic [2:0]           nbytes_i,
  output logic [7:0]           byte_o,
  output logic                 last_o
);

  always_comb begin
    byte_o = data_i[7:0];
    case (idx_i)
      2'd1:    byte_o = data_i[15:8];
      2'd2:    byte_o = data_i[23:16];
      2'd3:    byte_o = data_i[31:24];
      default: byte_o = data_i[7:0];
    endcase
  end

  assign last_o = (({1'b0, idx_i}) + 3'd1) == nbytes_i;

endmodule

// File: rtl/store_commit_port.sv
// Commit-time memory responder: serialises committed stores and IO loads onto
// the 8-bit RAM/IO bus. Optional feature macro: STORE_COMMIT_IOFULL_EN.
module store_commit_port
  import store_commit_port_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 if_out_mem,
  input  logic [5:0]           out_mem_size,
  input  logic [addrWidth-1:0] out_mem_addr,
  input  logic [dataWidth-1:0] out_mem_data,
  output logic                 if_stored,
  input  logic                 if_out_mem_io,
  output logic                 if_get_mem,
  output logic [dataWidth-1:0] data_mem,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic [addrWidth-1:0] mem_a,
  output logic [7:0]           mem_dout,
  output logic                 mem_wr,
  input  logic [7:0]           mem_din,
  input  logic                 io_buffer_full,
  output logic [2:0]           dbg_state
);

  // Bus handshake: bus_req rises on entering REQ and is held through the last
  // bus cycle; an edge with bus_req=1 and bus_gnt=1 starts the transfer, after
  // which the grant is assumed to stay with us until bus_req falls.
  state_t               state_q;
  logic                 st_pend_q, io_pend_q, st_clr_q;
  logic [addrWidth-1:0] st_addr_q;
  logic [dataWidth-1:0] st_data_q;
  logic [2:0]           st_n_q;
  logic [1:0]           i_q;
  logic                 last_q;
  logic                 bus_req_q, mem_wr_q, if_stored_q, if_get_mem_q;
  logic [addrWidth-1:0] mem_a_q;
  logic [7:0]           mem_dout_q;
  logic [dataWidth-1:0] data_mem_q;

  logic [1:0] lane_idx;
  logic [7:0] lane_byte;
  logic       lane_last;
  logic       wr_stall;

  assign lane_idx = (state_q == WR) ? (i_q + 2'd1) : 2'd0;

  byte_lane_sel u_lane (
    .data_i   (st_data_q),
    .idx_i    (lane_idx),
    .nbytes_i (st_n_q),
    .byte_o   (lane_byte),
    .last_o   (lane_last)
  );

`ifdef STORE_COMMIT_IOFULL_EN
  assign wr_stall = (state_q == WR) && (mem_a_q >= IO_ADDR) && io_buffer_full;
`else
  logic unused_iofull;
  assign unused_iofull = io_buffer_full;
  assign wr_stall      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      st_pend_q    <= 1'b0;
      io_pend_q    <= 1'b0;
      st_clr_q     <= 1'b0;
      st_addr_q    <= '0;
      st_data_q    <= '0;
      st_n_q       <= '0;
      i_q          <= '0;
      last_q       <= 1'b0;
      bus_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      if_stored_q  <= 1'b0;
      if_get_mem_q <= 1'b0;
      data_mem_q   <= '0;
    end else if (rdy) begin
      if (if_out_mem && !st_pend_q) begin
        st_pend_q <= 1'b1;
        st_addr_q <= out_mem_addr;
        st_data_q <= out_mem_data;
        st_n_q    <= size_bytes(out_mem_size);
        st_clr_q  <= clear;
      end else if (clear && st_pend_q) begin
        st_clr_q <= 1'b1;
      end

      if (clear)              io_pend_q <= 1'b0;
      else if (if_out_mem_io) io_pend_q <= 1'b1;

      if_stored_q  <= 1'b0;
      if_get_mem_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (st_pend_q || (io_pend_q && !clear)) begin
            state_q   <= REQ;
            bus_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (st_pend_q) begin
            if (bus_gnt) begin
              state_q    <= WR;
              mem_a_q    <= st_addr_q + {30'd0, lane_idx};
              mem_dout_q <= lane_byte;
              mem_wr_q   <= 1'b1;
              i_q        <= lane_idx;
              last_q     <= lane_last;
            end
          end else if (clear || !io_pend_q) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
          end else if (bus_gnt) begin
            state_q  <= RD;
            mem_a_q  <= IO_ADDR;
            mem_wr_q <= 1'b0;
          end
        end
        WR: begin
          if (!wr_stall) begin
            if (last_q) begin
              state_q     <= DONE_S;
              mem_wr_q    <= 1'b0;
              bus_req_q   <= 1'b0;
              if_stored_q <= !(st_clr_q || clear);
            end else begin
              mem_a_q    <= st_addr_q + {30'd0, lane_idx};
              mem_dout_q <= lane_byte;
              i_q        <= lane_idx;
              last_q     <= lane_last;
            end
          end
        end
        RD: begin
          if (clear) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
          end else begin
            state_q <= CAP;
          end
        end
        CAP: begin
          bus_req_q <= 1'b0;
          if (clear) begin
            state_q <= IDLE;
          end else begin
            state_q      <= DONE_L;
            data_mem_q   <= {24'd0, mem_din};
            if_get_mem_q <= 1'b1;
          end
        end
        DONE_S: begin
          st_pend_q <= 1'b0;
          state_q   <= IDLE;
        end
        DONE_L: begin
          io_pend_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
          mem_wr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_stored  = if_stored_q;
  assign if_get_mem = if_get_mem_q;
  assign data_mem   = data_mem_q;
  assign bus_req    = bus_req_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q && rdy && !wr_stall;
  assign dbg_state  = state_q;

endmodule
